segre_mem_arbiter: RTL and testbench

Arbitrates the single shared memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage / data cache + store buffer). Captures the winning request, holds it stable on the memory port until mem_ready_i, then returns data and a one-cycle ready pulse to the owner only. Data side has priority; a streak counter guarantees IF forward progress. Sits between the core stages and the external memory port; replaces the combinational sel_mem_req mux.

---
 rtl/segre_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_segre_mem_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter
//   Shares the single external memory port between the instruction-fetch
//   requester (IF) and the data requester (DC: data cache + store buffer).
//   A winning request is captured in IDLE and held stable on the memory port
//   until mem_ready_i. Read data and a one-cycle ready pulse go to the owner only.
//   The data side has priority. A streak counter forces an IF grant after
//   MAX_DATA_STREAK consecutive data grants taken while IF was waiting.
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   if_req_i/if_addr_i              IF line-read request (level)
//   if_ready_o/if_rd_data_o         IF completion pulse and line
//   dc_req_i/dc_wr_i/dc_addr_i      data request (level), write flag, address
//   dc_type_i/dc_wr_data_i          data op type, write line
//   dc_ready_o/dc_rd_data_o         data completion pulse and line
//   mem_addr_o/mem_rd_o/mem_wr_o    memory address and strobes
//   mem_data_type_o/mem_wr_data_o   memory op type and write line
//   mem_rd_data_i/mem_ready_i       memory read line and completion
//   sel_mem_o                       owner: 1 = data, 0 = IF/none
//   busy_o                          transaction in flight
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no transaction, requests sampled and arbitrated
// BUSY_IF | IF line read on the memory port
// BUSY_DC | data read/write on the memory port

module segre_mem_arbiter #(
  parameter int ADDR_SIZE       = 32,
  parameter int LINE_BYTES      = 16,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    if_req_i,
  input  logic [ADDR_SIZE-1:0]    if_addr_i,
  output logic                    if_ready_o,
  output logic [LINE_BYTES*8-1:0] if_rd_data_o,
  input  logic                    dc_req_i,
  input  logic                    dc_wr_i,
  input  logic [ADDR_SIZE-1:0]    dc_addr_i,
  input  logic [1:0]              dc_type_i,
  input  logic [LINE_BYTES*8-1:0] dc_wr_data_i,
  output logic                    dc_ready_o,
  output logic [LINE_BYTES*8-1:0] dc_rd_data_o,
  output logic [ADDR_SIZE-1:0]    mem_addr_o,
  output logic                    mem_rd_o,
  output logic                    mem_wr_o,
  output logic [1:0]              mem_data_type_o,
  output logic [LINE_BYTES*8-1:0] mem_wr_data_o,
  input  logic [LINE_BYTES*8-1:0] mem_rd_data_i,
  input  logic                    mem_ready_i,
  output logic                    sel_mem_o,
  output logic                    busy_o
);

  localparam int LW = LINE_BYTES * 8;
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [1:0] TYPE_WORD = 2'd2;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DC} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            grant_if, grant_dc;

  logic [ADDR_SIZE-1:0] addr_q;
  logic [1:0]           type_q;
  logic                 wr_q;
  logic [LW-1:0]        wdata_q;

  // State and streak register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Request capture: the memory port is driven only from these registers,
  // so requester inputs may change freely once granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      type_q  <= TYPE_WORD;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_dc) begin
      addr_q  <= dc_addr_i;
      type_q  <= dc_type_i;
      wr_q    <= dc_wr_i;
      wdata_q <= dc_wr_data_i;
    end else if (grant_if) begin
      addr_q  <= if_addr_i;
      type_q  <= TYPE_WORD;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end
  end

  // Next state, arbitration and streak update
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    grant_if = 1'b0;
    grant_dc = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i && (streak_q == STREAK_MAX)) grant_if = 1'b1;
        else if (dc_req_i)                        grant_dc = 1'b1;
        else if (if_req_i)                        grant_if = 1'b1;

        if (grant_dc) begin
          state_d = BUSY_DC;
          // The streak only counts data grants that made IF wait.
          if (!if_req_i)                   streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end else if (grant_if) begin
          state_d  = BUSY_IF;
          streak_d = '0;
        end
      end
      BUSY_IF, BUSY_DC: begin
        if (mem_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_addr_o      = '0;
    mem_data_type_o = TYPE_WORD;
    mem_wr_data_o   = '0;
    mem_rd_o        = 1'b0;
    mem_wr_o        = 1'b0;
    busy_o          = 1'b0;
    sel_mem_o       = 1'b0;
    if_ready_o      = 1'b0;
    if_rd_data_o    = '0;
    dc_ready_o      = 1'b0;
    dc_rd_data_o    = '0;
    if (state_q == BUSY_IF || state_q == BUSY_DC) begin
      mem_addr_o      = addr_q;
      mem_data_type_o = type_q;
      mem_wr_data_o   = wdata_q;
      mem_rd_o        = !wr_q;
      mem_wr_o        = wr_q;
      busy_o          = 1'b1;
      sel_mem_o       = (state_q == BUSY_DC);
      // A completion coinciding with reset is abandoned, not reported.
      if (mem_ready_i && !rst_i) begin
        if (state_q == BUSY_DC) begin
          dc_ready_o   = 1'b1;
          dc_rd_data_o = mem_rd_data_i;
        end else begin
          if_ready_o   = 1'b1;
          if_rd_data_o = mem_rd_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
module tb_segre_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam logic [1:0] T_HALF = 2'd1;
  localparam logic [1:0] T_WORD = 2'd2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_ready_o;
  logic [LW-1:0] if_rd_data_o;
  logic          dc_req_i;
  logic          dc_wr_i;
  logic [AW-1:0] dc_addr_i;
  logic [1:0]    dc_type_i;
  logic [LW-1:0] dc_wr_data_i;
  logic          dc_ready_o;
  logic [LW-1:0] dc_rd_data_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rd_o;
  logic          mem_wr_o;
  logic [1:0]    mem_data_type_o;
  logic [LW-1:0] mem_wr_data_o;
  logic [LW-1:0] mem_rd_data_i;
  logic          mem_ready_i;
  logic          sel_mem_o;
  logic          busy_o;

  int tests = 0;
  int fails = 0;

  segre_mem_arbiter #(.ADDR_SIZE(AW), .LINE_BYTES(16), .MAX_DATA_STREAK(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ready_o(if_ready_o), .if_rd_data_o(if_rd_data_o),
    .dc_req_i(dc_req_i), .dc_wr_i(dc_wr_i), .dc_addr_i(dc_addr_i),
    .dc_type_i(dc_type_i), .dc_wr_data_i(dc_wr_data_i),
    .dc_ready_o(dc_ready_o), .dc_rd_data_o(dc_rd_data_o),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_data_type_o(mem_data_type_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_rd_data_i(mem_rd_data_i), .mem_ready_i(mem_ready_i),
    .sel_mem_o(sel_mem_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = '0; dc_req_i = 0; dc_wr_i = 0; dc_addr_i = '0;
    dc_type_i = '0; dc_wr_data_i = '0; mem_rd_data_i = '0; mem_ready_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1; idle_inputs();
    step(); step();
    rst_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    tests++; if ({mem_rd_o, mem_wr_o, sel_mem_o} !== 3'b000) begin fails++; $display("FAIL reset_strobes: got rd=%b wr=%b sel=%b want 000", mem_rd_o, mem_wr_o, sel_mem_o); end
    tests++; if (mem_data_type_o !== T_WORD) begin fails++; $display("FAIL reset_type: got %0d want %0d", mem_data_type_o, T_WORD); end
    tests++; if (mem_addr_o !== '0 || mem_wr_data_o !== '0) begin fails++; $display("FAIL reset_buses: got addr=%h wdata=%h want 0", mem_addr_o, mem_wr_data_o); end
    tests++; if ({if_ready_o, dc_ready_o} !== 2'b00) begin fails++; $display("FAIL reset_ready: got if=%b dc=%b want 00", if_ready_o, dc_ready_o); end
  endtask

  task automatic test_if_read();
    logic [LW-1:0] line;
    line = 128'hA5A5_0001_0202_0303_0404_0505_0606_0707;
    do_reset();
    if_req_i = 1; if_addr_i = 32'h100;
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 2) begin mem_ready_i = 1; mem_rd_data_i = line; #1; end
      tests++; if (mem_rd_o !== 1'b1 || mem_wr_o !== 1'b0) begin fails++; $display("FAIL if_strobe c%0d: got rd=%b wr=%b want rd=1 wr=0", c, mem_rd_o, mem_wr_o); end
      tests++; if (mem_addr_o !== 32'h100 || mem_data_type_o !== T_WORD) begin fails++; $display("FAIL if_addr c%0d: got %h/%0d want 100/%0d", c, mem_addr_o, mem_data_type_o, T_WORD); end
      tests++; if (busy_o !== 1'b1 || sel_mem_o !== 1'b0) begin fails++; $display("FAIL if_busy c%0d: got busy=%b sel=%b want 1/0", c, busy_o, sel_mem_o); end
      tests++; if (if_ready_o !== (c == 2) || dc_ready_o !== 1'b0) begin fails++; $display("FAIL if_ready c%0d: got if=%b dc=%b want %0d/0", c, if_ready_o, dc_ready_o, (c == 2)); end
    end
    tests++; if (if_rd_data_o !== line) begin fails++; $display("FAIL if_line: got %h want %h", if_rd_data_o, line); end
    tests++; if (dc_rd_data_o !== '0) begin fails++; $display("FAIL if_dc_data: got %h want 0", dc_rd_data_o); end
    step();
    if_req_i = 0; mem_ready_i = 0; #1;
    tests++; if (busy_o !== 1'b0 || mem_rd_o !== 1'b0 || if_ready_o !== 1'b0) begin fails++; $display("FAIL if_done: got busy=%b rd=%b rdy=%b want 000", busy_o, mem_rd_o, if_ready_o); end
  endtask

  task automatic test_priority();
    logic [LW-1:0] l1, l2;
    l1 = {4{32'hDEAD_0001}}; l2 = {4{32'hBEEF_0002}};
    do_reset();
    if_req_i = 1; if_addr_i = 32'h400;
    dc_req_i = 1; dc_wr_i = 0; dc_addr_i = 32'h2004; dc_type_i = T_HALF;
    step();
    tests++; if (busy_o !== 1'b1 || sel_mem_o !== 1'b1) begin fails++; $display("FAIL pri_dc_first: got busy=%b sel=%b want 1/1", busy_o, sel_mem_o); end
    tests++; if (mem_addr_o !== 32'h2004 || mem_data_type_o !== T_HALF || mem_rd_o !== 1'b1) begin fails++; $display("FAIL pri_dc_port: got %h/%0d rd=%b want 2004/1 rd=1", mem_addr_o, mem_data_type_o, mem_rd_o); end
    mem_ready_i = 1; mem_rd_data_i = l1; #1;
    tests++; if (dc_ready_o !== 1'b1 || if_ready_o !== 1'b0 || dc_rd_data_o !== l1) begin fails++; $display("FAIL pri_dc_ready: got dc=%b if=%b data=%h want 1/0/%h", dc_ready_o, if_ready_o, dc_rd_data_o, l1); end
    step();
    dc_req_i = 0; mem_ready_i = 0; #1;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL pri_turnaround: got busy=%b want 0", busy_o); end
    step();
    tests++; if (busy_o !== 1'b1 || sel_mem_o !== 1'b0 || mem_addr_o !== 32'h400 || mem_data_type_o !== T_WORD) begin fails++; $display("FAIL pri_if_next: got busy=%b sel=%b addr=%h type=%0d want 1/0/400/2", busy_o, sel_mem_o, mem_addr_o, mem_data_type_o); end
    mem_ready_i = 1; mem_rd_data_i = l2; #1;
    tests++; if (if_ready_o !== 1'b1 || dc_ready_o !== 1'b0 || if_rd_data_o !== l2) begin fails++; $display("FAIL pri_if_ready: got if=%b dc=%b data=%h want 1/0/%h", if_ready_o, dc_ready_o, if_rd_data_o, l2); end
    step();
    if_req_i = 0; mem_ready_i = 0;
  endtask

  task automatic test_dc_write();
    logic [LW-1:0] a, b;
    a = {4{32'h1234_5678}}; b = {4{32'h0BAD_F00D}};
    do_reset();
    dc_req_i = 1; dc_wr_i = 1; dc_addr_i = 32'h3000; dc_type_i = T_WORD; dc_wr_data_i = a;
    step();
    dc_wr_data_i = b; dc_addr_i = 32'h5555; dc_wr_i = 0; mem_ready_i = 1; #1;
    tests++; if (mem_wr_o !== 1'b1 || mem_rd_o !== 1'b0) begin fails++; $display("FAIL wr_strobe: got wr=%b rd=%b want 1/0", mem_wr_o, mem_rd_o); end
    tests++; if (mem_wr_data_o !== a || mem_addr_o !== 32'h3000) begin fails++; $display("FAIL wr_captured: got %h @%h want %h @3000", mem_wr_data_o, mem_addr_o, a); end
    tests++; if (dc_ready_o !== 1'b1 || if_ready_o !== 1'b0) begin fails++; $display("FAIL wr_ready: got dc=%b if=%b want 1/0", dc_ready_o, if_ready_o); end
    step();
    dc_req_i = 0; mem_ready_i = 0; #1;
    tests++; if (mem_wr_o !== 1'b0 || busy_o !== 1'b0 || dc_ready_o !== 1'b0) begin fails++; $display("FAIL wr_one_cycle: got wr=%b busy=%b rdy=%b want 000", mem_wr_o, busy_o, dc_ready_o); end
  endtask

  task automatic test_streak();
    logic exp_sel [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int wait_c;
    do_reset();
    if_req_i = 1; if_addr_i = 32'h800;
    dc_req_i = 1; dc_wr_i = 0; dc_addr_i = 32'h9000; dc_type_i = T_WORD;
    for (int g = 0; g < 10; g++) begin
      wait_c = 0;
      while (busy_o !== 1'b1 && wait_c < 4) begin step(); wait_c++; end
      tests++;
      if (busy_o !== 1'b1) begin
        fails++; $display("FAIL streak_timeout g%0d: got busy=%b want 1", g, busy_o);
      end else if (sel_mem_o !== exp_sel[g]) begin
        fails++; $display("FAIL streak_order g%0d: got sel=%b want %b", g, sel_mem_o, exp_sel[g]);
      end
      mem_ready_i = 1;
      step();
      mem_ready_i = 0;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_idle_ready();
    do_reset();
    mem_ready_i = 1; mem_rd_data_i = {4{32'hFFFF_FFFF}};
    for (int c = 0; c < 2; c++) begin
      step();
      tests++; if ({if_ready_o, dc_ready_o, busy_o} !== 3'b000) begin fails++; $display("FAIL idle_ready c%0d: got if=%b dc=%b busy=%b want 000", c, if_ready_o, dc_ready_o, busy_o); end
    end
    mem_ready_i = 0;
  endtask

  task automatic test_drop_req();
    do_reset();
    dc_req_i = 1; dc_wr_i = 0; dc_addr_i = 32'h7000; dc_type_i = T_HALF;
    step();
    dc_req_i = 0;
    step();
    tests++; if (busy_o !== 1'b1 || sel_mem_o !== 1'b1 || mem_addr_o !== 32'h7000) begin fails++; $display("FAIL drop_hold: got busy=%b sel=%b addr=%h want 1/1/7000", busy_o, sel_mem_o, mem_addr_o); end
    mem_ready_i = 1; #1;
    tests++; if (dc_ready_o !== 1'b1) begin fails++; $display("FAIL drop_ready: got %b want 1", dc_ready_o); end
    step();
    mem_ready_i = 0;
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] line;
    line = {4{32'hCAFE_0003}};
    do_reset();
    dc_req_i = 1; dc_wr_i = 1; dc_addr_i = 32'h6000; dc_wr_data_i = {4{32'h1}};
    step();
    tests++; if (busy_o !== 1'b1 || sel_mem_o !== 1'b1) begin fails++; $display("FAIL rstmid_busy: got busy=%b sel=%b want 1/1", busy_o, sel_mem_o); end
    rst_i = 1; dc_req_i = 0;
    step();
    tests++; if ({mem_rd_o, mem_wr_o, busy_o, dc_ready_o} !== 4'b0000) begin fails++; $display("FAIL rstmid_drop: got rd=%b wr=%b busy=%b rdy=%b want 0000", mem_rd_o, mem_wr_o, busy_o, dc_ready_o); end
    rst_i = 0;
    if_req_i = 1; if_addr_i = 32'hA00;
    step();
    tests++; if (busy_o !== 1'b1 || sel_mem_o !== 1'b0 || mem_addr_o !== 32'hA00 || mem_rd_o !== 1'b1) begin fails++; $display("FAIL rstmid_if: got busy=%b sel=%b addr=%h rd=%b want 1/0/a00/1", busy_o, sel_mem_o, mem_addr_o, mem_rd_o); end
    mem_ready_i = 1; mem_rd_data_i = line; #1;
    tests++; if (if_ready_o !== 1'b1 || if_rd_data_o !== line) begin fails++; $display("FAIL rstmid_if_ready: got %b/%h want 1/%h", if_ready_o, if_rd_data_o, line); end
    step();
    idle_inputs();
  endtask

  initial begin
    rst_i = 1; idle_inputs();
    test_reset();
    test_if_read();
    test_priority();
    test_dc_write();
    test_streak();
    test_idle_ready();
    test_drop_req();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
